// File: rtl/gpu_cmd_parser.sv
// gpu_cmd_parser: reader side of the SimpleGPU input command FIFO.
// Pops header + operand words from a show-ahead FIFO, assembles a draw
// command, and hands it to the rasterizer front end over valid/ready.
// NOP headers are discarded silently; illegal headers are discarded,
// flagged with a one-cycle pulse and counted in a saturating counter.
module gpu_cmd_parser #(
    parameter int ERR_W = 8,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_r_data,
    output logic             fifo_read,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_opcode,
    output logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      cmd_op0,
    output logic [31:0]      cmd_op1,
    output logic [31:0]      cmd_op2,
    output logic [31:0]      cmd_op3,
    output logic             busy,
    output logic             bad_opcode,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        OPERANDS,
        ISSUE
    } state_t;

    state_t           state;
    logic [7:0]       opcode_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      op_q [4];
    logic [2:0]       remaining;
    logic [1:0]       index;

    logic [2:0]       hdr_count;
    logic             hdr_legal;

    // Decode the operand count of the header currently at the FIFO head.
    always_comb begin
        hdr_count = 3'd0;
        hdr_legal = 1'b1;
        case (fifo_r_data[31:24])
            8'h00:   hdr_count = 3'd0;
            8'h01:   hdr_count = 3'd1;
            8'h02:   hdr_count = 3'd2;
            8'h03:   hdr_count = 3'd3;
            8'h04:   hdr_count = 3'd3;
            8'h05:   hdr_count = 3'd4;
            default: hdr_legal = 1'b0;
        endcase
    end

    // Pop whenever the parser can consume a word and one is available.
    assign fifo_read = ((state == IDLE) || (state == OPERANDS)) && !fifo_empty;

    assign busy       = (state != IDLE);
    assign cmd_opcode = opcode_q;
    assign cmd_tag    = tag_q;
    assign cmd_op0    = op_q[0];
    assign cmd_op1    = op_q[1];
    assign cmd_op2    = op_q[2];
    assign cmd_op3    = op_q[3];

    // Parser state machine: header capture, operand collection, command hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            opcode_q   <= '0;
            tag_q      <= '0;
            for (int i = 0; i < 4; i++) op_q[i] <= '0;
            remaining  <= '0;
            index      <= '0;
            cmd_valid  <= 1'b0;
            bad_opcode <= 1'b0;
            err_count  <= '0;
        end else begin
            bad_opcode <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_read) begin
                        opcode_q  <= fifo_r_data[31:24];
                        tag_q     <= fifo_r_data[TAG_W-1:0];
                        for (int i = 0; i < 4; i++) op_q[i] <= '0;
                        remaining <= hdr_count;
                        index     <= '0;
                        if (!hdr_legal) begin
                            bad_opcode <= 1'b1;
                            if (err_count != {ERR_W{1'b1}})
                                err_count <= err_count + ERR_W'(1);
                        end else if (hdr_count != 3'd0) begin
                            state <= OPERANDS;
                        end
                    end
                end
                OPERANDS: begin
                    if (fifo_read) begin
                        op_q[index] <= fifo_r_data;
                        index       <= index + 2'd1;
                        remaining   <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// tb_gpu_cmd_parser: scoreboard bench for gpu_cmd_parser.
// A behavioural show-ahead FIFO feeds the parser; directed command streams
// push their expected commands into a queue that a monitor checks against
// every presented command.
module tb_gpu_cmd_parser;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] tag;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
    } cmd_t;

    logic        tb_clk;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_r_data;
    logic        fifo_read;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_tag;
    logic [31:0] cmd_op0, cmd_op1, cmd_op2, cmd_op3;
    logic        busy;
    logic        bad_opcode;
    logic [7:0]  err_count;

    logic [31:0] fifo_q [$];
    cmd_t        sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_pop_cycle = 0;
    int bad_seen = 0;
    int exp_bad  = 0;
    int exp_err  = 0;
    logic pop_pending    = 1'b0;
    logic prev_valid     = 1'b0;
    logic prev_handshake = 1'b0;

    gpu_cmd_parser #(.ERR_W(8), .TAG_W(16)) dut (
        .clk         (tb_clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_read   (fifo_read),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_tag     (cmd_tag),
        .cmd_op0     (cmd_op0),
        .cmd_op1     (cmd_op1),
        .cmd_op2     (cmd_op2),
        .cmd_op3     (cmd_op3),
        .busy        (busy),
        .bad_opcode  (bad_opcode),
        .err_count   (err_count)
    );

    // Free-running clock.
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] word);
        fifo_q.push_back(word);
    endtask

    task automatic expect_cmd(input logic [7:0] opc, input logic [15:0] tag,
                              input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [31:0] o3);
        cmd_t c;
        c.opcode = opc; c.tag = tag;
        c.op0 = o0; c.op1 = o1; c.op2 = o2; c.op3 = o3;
        sb_q.push_back(c);
    endtask

    task automatic expect_illegal();
        exp_bad++;
        if (exp_err < 255) exp_err++;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (!(fifo_q.size() == 0 && sb_q.size() == 0 && !busy && !cmd_valid)) begin
            @(negedge tb_clk);
            n++;
            if (n > max_cycles) begin
                check_output("idle_timeout", 32'(n), 32'(max_cycles));
                break;
            end
        end
        repeat (2) @(negedge tb_clk);
    endtask

    // Show-ahead FIFO model: pops at the edge where the parser asked for a word.
    always @(posedge tb_clk) begin
        cycle++;
        if (pop_pending) begin
            last_pop_cycle = cycle;
            if (fifo_q.size() == 0) check_output("pop_from_empty", 32'd1, 32'd0);
            else void'(fifo_q.pop_front());
        end
        #1;
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end

    // Monitor: compares every presented command against the scoreboard head.
    always @(negedge tb_clk) begin
        pop_pending = fifo_read;
        if (reset) begin
            prev_valid     = 1'b0;
            prev_handshake = 1'b0;
        end else begin
            if (fifo_empty) check_output("no_pop_when_empty", 32'(fifo_read), 32'd0);
            if (prev_handshake) check_output("valid_drop_after_handshake", 32'(cmd_valid), 32'd0);
            if (bad_opcode) bad_seen++;
            if (cmd_valid) begin
                check_output("no_pop_in_issue", 32'(fifo_read), 32'd0);
                check_output("busy_in_issue", 32'(busy), 32'd1);
                if (!prev_valid)
                    check_output("valid_after_last_pop", 32'(cycle - last_pop_cycle), 32'd0);
                if (sb_q.size() == 0) begin
                    check_output("unexpected_cmd", 32'(cmd_opcode), 32'hFFFF_FFFF);
                end else begin
                    check_output("cmd_opcode", 32'(cmd_opcode), 32'(sb_q[0].opcode));
                    check_output("cmd_tag",    32'(cmd_tag),    32'(sb_q[0].tag));
                    check_output("cmd_op0",    cmd_op0,         sb_q[0].op0);
                    check_output("cmd_op1",    cmd_op1,         sb_q[0].op1);
                    check_output("cmd_op2",    cmd_op2,         sb_q[0].op2);
                    check_output("cmd_op3",    cmd_op3,         sb_q[0].op3);
                    if (cmd_ready) void'(sb_q.pop_front());
                end
            end
            prev_valid     = cmd_valid;
            prev_handshake = cmd_valid && cmd_ready;
        end
    end

    // Directed scenarios.
    initial begin
        int n;
        reset       = 1'b1;
        cmd_ready   = 1'b0;
        fifo_empty  = 1'b1;
        fifo_r_data = 32'h0;
        repeat (3) @(posedge tb_clk);
        #1 reset = 1'b0;

        // Reset state and an idle FIFO.
        @(negedge tb_clk);
        check_output("rst_cmd_opcode", 32'(cmd_opcode), 32'd0);
        check_output("rst_cmd_tag",    32'(cmd_tag),    32'd0);
        check_output("rst_cmd_op0",    cmd_op0,         32'd0);
        check_output("rst_cmd_op3",    cmd_op3,         32'd0);
        check_output("rst_bad_opcode", 32'(bad_opcode), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check_output("idle_fifo_read", 32'(fifo_read), 32'd0);
            check_output("idle_cmd_valid", 32'(cmd_valid), 32'd0);
            check_output("idle_busy",      32'(busy),      32'd0);
            check_output("idle_err_count", 32'(err_count), 32'd0);
            @(negedge tb_clk);
        end

        // PIXEL with the downstream always ready.
        cmd_ready = 1'b1;
        expect_cmd(8'h02, 16'h0ABC, 32'h0010_0020, 32'h00FF_0000, 32'h0, 32'h0);
        apply_stimulus(32'h0200_0ABC);
        apply_stimulus(32'h0010_0020);
        apply_stimulus(32'h00FF_0000);
        wait_idle(50);

        // TRI held by back-pressure while the next command waits in the FIFO.
        @(posedge tb_clk); #1 cmd_ready = 1'b0;
        expect_cmd(8'h05, 16'h0001, 32'd1, 32'd2, 32'd3, 32'd4);
        apply_stimulus(32'h0500_0001);
        for (int i = 1; i <= 4; i++) apply_stimulus(32'(i));
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge tb_clk);
            n++;
        end
        check_output("tri_valid_seen", 32'(cmd_valid), 32'd1);
        expect_cmd(8'h02, 16'h1111, 32'h0000_000A, 32'h0000_000B, 32'h0, 32'h0);
        apply_stimulus(32'h0200_1111);
        apply_stimulus(32'h0000_000A);
        apply_stimulus(32'h0000_000B);
        repeat (10) @(negedge tb_clk);
        @(posedge tb_clk); #1 cmd_ready = 1'b1;
        wait_idle(50);

        // NOP, illegal header, then CLEAR.
        expect_illegal();
        expect_cmd(8'h01, 16'h0005, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        apply_stimulus(32'h0000_0000);
        apply_stimulus(32'h7700_0000);
        apply_stimulus(32'h0100_0005);
        apply_stimulus(32'h1234_5678);
        wait_idle(50);
        check_output("err_count_one", 32'(err_count), 32'(exp_err));
        check_output("bad_pulse_one", 32'(bad_seen), 32'(exp_bad));

        // LINE that stalls on an empty FIFO mid-command.
        expect_cmd(8'h03, 16'h0042, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0);
        apply_stimulus(32'h0300_0042);
        apply_stimulus(32'h0000_0011);
        n = 0;
        while ((fifo_q.size() != 0 || !fifo_empty) && n < 50) begin
            @(negedge tb_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_clk);
            check_output("stall_busy",  32'(busy),      32'd1);
            check_output("stall_valid", 32'(cmd_valid), 32'd0);
        end
        apply_stimulus(32'h0000_0022);
        apply_stimulus(32'h0000_0033);
        wait_idle(50);

        // Same stall, but reset discards the partial command.
        apply_stimulus(32'h0300_0077);
        apply_stimulus(32'h0000_DEAD);
        n = 0;
        while ((fifo_q.size() != 0 || !fifo_empty) && n < 50) begin
            @(negedge tb_clk);
            n++;
        end
        repeat (2) @(negedge tb_clk);
        check_output("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge tb_clk); #1 reset = 1'b1;
        @(posedge tb_clk); #1 reset = 1'b0;
        exp_err = 0;
        @(negedge tb_clk);
        check_output("mid_reset_valid",  32'(cmd_valid),  32'd0);
        check_output("mid_reset_busy",   32'(busy),       32'd0);
        check_output("mid_reset_err",    32'(err_count),  32'd0);
        check_output("mid_reset_opcode", 32'(cmd_opcode), 32'd0);
        check_output("mid_reset_op0",    cmd_op0,         32'd0);
        expect_cmd(8'h02, 16'h0099, 32'h0000_0007, 32'h0000_0008, 32'h0, 32'h0);
        apply_stimulus(32'h0200_0099);
        apply_stimulus(32'h0000_0007);
        apply_stimulus(32'h0000_0008);
        wait_idle(50);

        // Long run of illegal headers saturates the error counter.
        for (int i = 0; i < 300; i++) begin
            expect_illegal();
            apply_stimulus(32'hFF00_0000 | 32'(i));
        end
        wait_idle(2000);
        check_output("err_count_sat", 32'(err_count), 32'd255);
        check_output("err_count_model", 32'(err_count), 32'(exp_err));
        check_output("bad_pulse_total", 32'(bad_seen), 32'(exp_bad));
        check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gpu_cmd_parser.md
Name: gpu_cmd_parser

Overview:
- Reader side of the input command FIFO in SimpleGPU.
- Pops 32-bit words from the show-ahead input FIFO and assembles them into complete draw commands: one header word plus a fixed number of operand words per opcode.
- Presents each command to the rasterizer front end on a valid/ready handshake.
- Drops NOPs, and drops and counts illegal opcodes.

Parameters:
- ERR_W, 8, width of saturating illegal-opcode counter
- TAG_W, 16, width of command tag carried from header bits [TAG_W-1:0]

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- fifo_empty  input  1  input FIFO empty; fifo_r_data is valid when 0
- fifo_r_data  input  32  head word of FIFO (show-ahead)
- fifo_read  output  1  pop strobe; head advances at this rising edge
- cmd_valid  output  1  assembled command available
- cmd_ready  input  1  downstream accepts command when high with cmd_valid
- cmd_opcode  output  8  opcode of current command
- cmd_tag  output  TAG_W  tag from header
- cmd_op0  output  32  operand 0
- cmd_op1  output  32  operand 1
- cmd_op2  output  32  operand 2
- cmd_op3  output  32  operand 3
- busy  output  1  high in any state other than IDLE
- bad_opcode  output  1  one-cycle pulse when an illegal header is dropped
- err_count  output  ERR_W  count of illegal headers, saturates at all-ones

Behaviour:
- Header format: [31:24] opcode, [23:TAG_W] ignored, [TAG_W-1:0] tag.
- Operand counts by opcode:
  - 0x00 NOP: 0 operands, never issued
  - 0x01 CLEAR: 1 (color)
  - 0x02 PIXEL: 2 (xy, color)
  - 0x03 LINE: 3 (xy0, xy1, color)
  - 0x04 RECT: 3 (xy0, xy1, color)
  - 0x05 TRI: 4 (xy0, xy1, xy2, color)
  - all other opcodes are illegal.
- Reset values: all outputs 0; state IDLE; operand registers 0; err_count 0.
- fifo_read is combinational: (state==IDLE or state==OPERANDS) and !fifo_empty. It is never asserted when fifo_empty=1.
- IDLE:
  - On pop, latch opcode and tag, clear op0..op3, and set remaining count and index 0.
  - Legal opcode with count>0: go to OPERANDS.
  - CLEAR..TRI always have count>0.
  - NOP: stay in IDLE, nothing issued.
  - Illegal opcode: stay in IDLE, pulse bad_opcode next cycle, increment err_count (saturating).
- OPERANDS:
  - Each pop writes fifo_r_data into op[index], increments index, decrements remaining.
  - The pop that brings remaining to 0 moves to ISSUE.
  - Empty FIFO stalls the parser with no state change and no timeout.
- ISSUE:
  - cmd_valid=1; cmd_opcode, cmd_tag and cmd_op0..3 held stable until cmd_ready=1.
  - On handshake, go to IDLE next cycle with cmd_valid=0.
  - No FIFO pop occurs in ISSUE.
- Unused operand outputs read 0.
- Minimum occupancy: a command with N operands needs N+1 pop cycles plus at least 1 ISSUE cycle. The first cmd_valid appears the cycle after the last operand pop.
- cmd_ready while cmd_valid=0 is ignored.
- bad_opcode is exactly one cycle wide even for back-to-back illegal headers; each illegal header increments err_count once.
- err_count holds at 2^ERR_W-1 once reached.
- reset mid-command (any state) discards the partial command immediately: state IDLE, cmd_valid=0, registers cleared. The FIFO content is governed by the FIFO's own reset.
- busy=1 in OPERANDS and ISSUE.

Test Plan:
- Reset then no writes: fifo_empty=1 for 20 cycles -> fifo_read=0, cmd_valid=0, busy=0, err_count=0 throughout.
- Push header 0x0200_0ABC, 0x0010_0020, 0x00FF_0000 -> after 3 pops, cmd_valid=1, cmd_opcode=0x02, cmd_tag=0x0ABC, op0=0x0010_0020, op1=0x00FF_0000, op2=op3=0. With cmd_ready=1, cmd_valid drops on the next cycle.
- TRI header 0x0500_0001 plus 4 operands 1,2,3,4, with cmd_ready=0 for 10 cycles -> cmd_valid stays 1, outputs stable, fifo_read=0 while held. Raise cmd_ready -> one handshake, returns to IDLE.
- Stream 0x0000_0000 (NOP), 0x7700_0000 (illegal), 0x0100_0005, 0x1234_5678 -> no issue for the NOP, bad_opcode pulses once, err_count=1, then CLEAR is issued with tag 5 and op0=0x1234_5678.
- LINE header plus 1 operand, then FIFO empty for 5 cycles, then 2 more operands -> parser stalls in OPERANDS with busy=1, then issues op0..op2 correct. Repeat with reset asserted during the stall -> cmd_valid=0, busy=0, and the next header is parsed cleanly.
- 300 illegal headers with ERR_W=8 -> err_count saturates at 255, with bad_opcode pulsing once per header.
